// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// ttt_pkg : shared programming opcodes and sweep FSM state encoding
// Rev 1.0
// ============================================================================
package ttt_pkg;

    // Opcodes 001..011 belong to the processor core; the router only decodes 1xx.
    localparam logic [2:0] c_HDR_CORE_0 = 3'b001;
    localparam logic [2:0] c_HDR_CORE_1 = 3'b010;
    localparam logic [2:0] c_HDR_CORE_2 = 3'b011;
    localparam logic [2:0] c_HDR_TGT    = 3'b100;
    localparam logic [2:0] c_HDR_GW     = 3'b101;
    localparam logic [2:0] c_HDR_BW     = 3'b110;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/tt_um_jleugeri_ttt_token_router_if.sv
`default_nettype none
// ============================================================================
// tt_um_jleugeri_ttt_token_router_if : trigger, programming, injection, core I/O
// Rev 1.0
// ============================================================================
interface tt_um_jleugeri_ttt_token_router_if #(
    parameter int NUM_PROCESSORS  = 10,
    parameter int NEW_TOKENS_BITS = 4,
    parameter int PROG_WIDTH      = 8
);
    localparam int IDW = $clog2(NUM_PROCESSORS + 1);

    logic                              clock_slow;
    logic                              hold;
    logic [2:0]                        prog_header;
    logic [IDW-1:0]                    prog_id;
    logic [PROG_WIDTH-1:0]             prog_data;
    logic                              ext_valid;
    logic [IDW-1:0]                    ext_id;
    logic signed [NEW_TOKENS_BITS-1:0] ext_good;
    logic signed [NEW_TOKENS_BITS-1:0] ext_bad;
    logic                              token_start;
    logic                              token_stop;
    logic [IDW-1:0]                    neuron_id;
    logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens;
    logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens;

    modport master (
        output clock_slow, hold, prog_header, prog_id, prog_data,
               ext_valid, ext_id, ext_good, ext_bad, token_start, token_stop,
        input  neuron_id, new_good_tokens, new_bad_tokens
    );

    modport slave (
        input  clock_slow, hold, prog_header, prog_id, prog_data,
               ext_valid, ext_id, ext_good, ext_bad, token_start, token_stop,
        output neuron_id, new_good_tokens, new_bad_tokens
    );

endinterface
`default_nettype wire

// File: rtl/tt_um_jleugeri_ttt_sat_accum.sv
`default_nettype none
// ============================================================================
// tt_um_jleugeri_ttt_sat_accum : pending + (+/-weight) + injection, saturated once
// Rev 1.0
// ============================================================================
module tt_um_jleugeri_ttt_sat_accum #(
    parameter int N = 4
) (
    input  logic signed [N-1:0] cur_i,
    input  logic                clear_i,
    input  logic signed [N-1:0] weight_i,
    input  logic                add_i,
    input  logic                sub_i,
    input  logic signed [N-1:0] inj_i,
    input  logic                inj_en_i,
    output logic signed [N-1:0] sum_o
);
    // Two guard bits hold the worst case (3 * -2^(N-1)) without wrapping.
    localparam int W = N + 2;
    localparam logic signed [W-1:0] c_MAX = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [W-1:0] c_MIN = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [W-1:0] w_cur;
    logic signed [W-1:0] w_rt;
    logic signed [W-1:0] w_inj;
    logic signed [W-1:0] w_sum;

    always_comb begin
        w_cur = clear_i ? '0 : {{2{cur_i[N-1]}}, cur_i};
        w_rt  = '0;
        if (add_i && !sub_i) begin
            w_rt = {{2{weight_i[N-1]}}, weight_i};
        end else if (sub_i && !add_i) begin
            w_rt = -{{2{weight_i[N-1]}}, weight_i};
        end
        w_inj = inj_en_i ? {{2{inj_i[N-1]}}, inj_i} : '0;
        w_sum = w_cur + w_rt + w_inj;
        if (w_sum > c_MAX) begin
            sum_o = c_MAX[N-1:0];
        end else if (w_sum < c_MIN) begin
            sum_o = c_MIN[N-1:0];
        end else begin
            sum_o = w_sum[N-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tt_um_jleugeri_ttt_token_router.sv
`default_nettype none
// ============================================================================
// tt_um_jleugeri_ttt_token_router : neuron sweep sequencer and weighted token router
// Rev 1.0
// ============================================================================
module tt_um_jleugeri_ttt_token_router #(
    parameter int NUM_PROCESSORS  = 10,
    parameter int NEW_TOKENS_BITS = 4,
    parameter int PROG_WIDTH      = 8
) (
    input  logic                             clock_fast,
    input  logic                             reset,
    tt_um_jleugeri_ttt_token_router_if.slave bus
);
    import ttt_pkg::*;

    localparam int IDW = $clog2(NUM_PROCESSORS + 1);
    localparam int N   = NEW_TOKENS_BITS;
    localparam logic [IDW-1:0] c_SENTINEL = IDW'(NUM_PROCESSORS);
    localparam logic [IDW-1:0] c_LAST_ID  = IDW'(NUM_PROCESSORS - 1);

    state_e              state_q, state_d;
    logic [IDW-1:0]      cnt_q, cnt_d;
    logic                slow_q;
    logic                start_req_q, start_req_d;
    logic [IDW-1:0]      d1_q, d2_q;
    logic [IDW-1:0]      tgt_q    [NUM_PROCESSORS];
    logic signed [N-1:0] gw_q     [NUM_PROCESSORS];
    logic signed [N-1:0] bw_q     [NUM_PROCESSORS];
    logic signed [N-1:0] pend_g_q [NUM_PROCESSORS];
    logic signed [N-1:0] pend_b_q [NUM_PROCESSORS];
    logic signed [N-1:0] pend_g_d [NUM_PROCESSORS];
    logic signed [N-1:0] pend_b_d [NUM_PROCESSORS];

    logic                w_slow_edge;
    logic                w_start;
    logic                w_sweeping;
    logic                w_ev_ok;
    logic [IDW-1:0]      w_src;
    logic [IDW-1:0]      w_tgt;
    logic signed [N-1:0] w_gw;
    logic signed [N-1:0] w_bw;
    logic                w_unused_prog;

    assign w_slow_edge = bus.clock_slow && !slow_q;
    assign w_start     = start_req_q || w_slow_edge;
    assign w_sweeping  = (state_q == SWEEP);

    assign bus.neuron_id       = w_sweeping ? cnt_q : c_SENTINEL;
    assign bus.new_good_tokens = w_sweeping ? pend_g_q[cnt_q] : '0;
    assign bus.new_bad_tokens  = w_sweeping ? pend_b_q[cnt_q] : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_req_d = w_start;
        case (state_q)
            IDLE: begin
                if (w_start && !bus.hold) begin
                    state_d     = SWEEP;
                    cnt_d       = '0;
                    start_req_d = 1'b0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + IDW'(1);
                if (cnt_q == c_LAST_ID) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The core's event outputs refer to the id issued two cycles earlier.
    assign w_ev_ok = (d2_q < c_SENTINEL);
    assign w_src   = w_ev_ok ? d2_q : '0;
    assign w_tgt   = tgt_q[w_src];
    assign w_gw    = gw_q[w_src];
    assign w_bw    = bw_q[w_src];

    generate
        for (genvar t = 0; t < NUM_PROCESSORS; t++) begin : g_tgt
            logic w_hit;
            logic w_inj;
            logic w_clr;

            // Targets >= NUM_PROCESSORS never match, so such events are dropped.
            assign w_hit = w_ev_ok && (w_tgt == IDW'(t));
            assign w_inj = bus.ext_valid && (bus.ext_id == IDW'(t));
            assign w_clr = w_sweeping && (cnt_q == IDW'(t));

            tt_um_jleugeri_ttt_sat_accum #(.N(N)) u_good (
                .cur_i    (pend_g_q[t]),
                .clear_i  (w_clr),
                .weight_i (w_gw),
                .add_i    (w_hit && bus.token_start),
                .sub_i    (w_hit && bus.token_stop),
                .inj_i    (bus.ext_good),
                .inj_en_i (w_inj),
                .sum_o    (pend_g_d[t])
            );

            tt_um_jleugeri_ttt_sat_accum #(.N(N)) u_bad (
                .cur_i    (pend_b_q[t]),
                .clear_i  (w_clr),
                .weight_i (w_bw),
                .add_i    (w_hit && bus.token_start),
                .sub_i    (w_hit && bus.token_stop),
                .inj_i    (bus.ext_bad),
                .inj_en_i (w_inj),
                .sum_o    (pend_b_d[t])
            );
        end
    endgenerate

    always_ff @(posedge clock_fast) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            slow_q      <= 1'b0;
            start_req_q <= 1'b0;
            d1_q        <= c_SENTINEL;
            d2_q        <= c_SENTINEL;
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
                pend_g_q[i] <= '0;
                pend_b_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slow_q      <= bus.clock_slow;
            start_req_q <= start_req_d;
            d1_q        <= bus.neuron_id;
            d2_q        <= d1_q;
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
                pend_g_q[i] <= pend_g_d[i];
                pend_b_q[i] <= pend_b_d[i];
            end
        end
    end

    // Routing tables are written only while reset is held and survive reset.
    always_ff @(posedge clock_fast) begin
        if (reset && (bus.prog_id < c_SENTINEL)) begin
            case (bus.prog_header)
                c_HDR_TGT: tgt_q[bus.prog_id] <= bus.prog_data[IDW-1:0];
                c_HDR_GW:  gw_q[bus.prog_id]  <= bus.prog_data[N-1:0];
                c_HDR_BW:  bw_q[bus.prog_id]  <= bus.prog_data[N-1:0];
                default: ;
            endcase
        end
    end

    assign w_unused_prog = ^bus.prog_data[PROG_WIDTH-1:IDW];

endmodule
`default_nettype wire

// File: tb/tb_tt_um_jleugeri_ttt_token_router.sv
`default_nettype none
// ============================================================================
// tb_tt_um_jleugeri_ttt_token_router : directed checks of sweep timing and routing
// Rev 1.0
// ============================================================================
module tb_tt_um_jleugeri_ttt_token_router;

    localparam int NUM = 10;
    localparam int IDW = 4;
    localparam int N   = 4;
    localparam logic [IDW-1:0] SENT = 4'd10;

    logic clock_fast = 1'b0;
    logic reset      = 1'b1;

    always #5 clock_fast = ~clock_fast;

    tt_um_jleugeri_ttt_token_router_if #(
        .NUM_PROCESSORS(NUM), .NEW_TOKENS_BITS(N), .PROG_WIDTH(8)
    ) bus ();

    tt_um_jleugeri_ttt_token_router #(
        .NUM_PROCESSORS(NUM), .NEW_TOKENS_BITS(N), .PROG_WIDTH(8)
    ) dut (
        .clock_fast (clock_fast),
        .reset      (reset),
        .bus        (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [IDW-1:0]      ids [NUM+3];
    logic signed [N-1:0] pg  [NUM];
    logic signed [N-1:0] pb  [NUM];

    task automatic tick;
        @(posedge clock_fast);
        #1;
    endtask

    task automatic prog(input logic [2:0] h, input logic [IDW-1:0] id, input logic [7:0] d);
        bus.prog_header = h;
        bus.prog_id     = id;
        bus.prog_data   = d;
        tick;
    endtask

    // One sweep from idle; the source-s event is driven when d2 == s.
    task automatic do_sweep(input logic [NUM-1:0] smask, input logic [NUM-1:0] tmask,
                            input int ext_k, input logic [IDW-1:0] eid,
                            input logic signed [N-1:0] eg, input logic signed [N-1:0] eb);
        int src;
        bus.clock_slow = 1'b1;
        tick;
        bus.clock_slow = 1'b0;
        for (int k = 0; k <= NUM + 2; k++) begin
            ids[k] = bus.neuron_id;
            if (k < NUM) begin
                pg[k] = bus.new_good_tokens;
                pb[k] = bus.new_bad_tokens;
            end
            src = k - 2;
            bus.token_start = (src >= 0 && src < NUM) ? smask[src] : 1'b0;
            bus.token_stop  = (src >= 0 && src < NUM) ? tmask[src] : 1'b0;
            bus.ext_valid   = (k == ext_k);
            bus.ext_id      = eid;
            bus.ext_good    = eg;
            bus.ext_bad     = eb;
            tick;
        end
        bus.token_start = 1'b0;
        bus.token_stop  = 1'b0;
        bus.ext_valid   = 1'b0;
    endtask

    task automatic test_reset;
        tick;
        checks++; if (bus.neuron_id !== SENT) begin failures++; $display("FAIL reset_id got=%0d exp=%0d", bus.neuron_id, SENT); end
        checks++; if (bus.new_good_tokens !== 4'sd0) begin failures++; $display("FAIL reset_good got=%0d exp=0", bus.new_good_tokens); end
        checks++; if (bus.new_bad_tokens !== 4'sd0) begin failures++; $display("FAIL reset_bad got=%0d exp=0", bus.new_bad_tokens); end
        for (int s = 0; s < NUM; s++) begin
            prog(3'b100, IDW'(s), 8'd10);
            prog(3'b101, IDW'(s), 8'd0);
            prog(3'b110, IDW'(s), 8'd0);
        end
        prog(3'b100, 4'd2, 8'd5);  prog(3'b101, 4'd2, 8'd3);
        prog(3'b100, 4'd7, 8'd5);  prog(3'b101, 4'd7, 8'd2);  prog(3'b110, 4'd7, 8'd1);
        prog(3'b100, 4'd0, 8'd8);  prog(3'b101, 4'd0, 8'd7);
        prog(3'b100, 4'd1, 8'd8);  prog(3'b101, 4'd1, 8'd7);
        prog(3'b100, 4'd3, 8'd8);  prog(3'b101, 4'd3, 8'd7);
        prog(3'b100, 4'd6, 8'd1);  prog(3'b110, 4'd6, 8'hF8);
        prog(3'b101, 4'd9, 8'd7);  prog(3'b110, 4'd9, 8'd7);
        prog(3'b001, 4'd2, 8'd0);  prog(3'b111, 4'd2, 8'd0);
        prog(3'b100, 4'd12, 8'd0);
        bus.prog_header = 3'b000;
        reset = 1'b0;
        tick;
        checks++; if (bus.neuron_id !== SENT) begin failures++; $display("FAIL post_reset_id got=%0d exp=%0d", bus.neuron_id, SENT); end
    endtask

    task automatic test_idle_sweep;
        logic [IDW-1:0] xi;
        do_sweep('0, '0, -1, '0, '0, '0);
        for (int k = 0; k <= NUM + 2; k++) begin
            xi = (k < NUM) ? IDW'(k) : SENT;
            checks++; if (ids[k] !== xi) begin failures++; $display("FAIL sweep_id k=%0d got=%0d exp=%0d", k, ids[k], xi); end
        end
        for (int i = 0; i < NUM; i++) begin
            checks++; if (pg[i] !== 4'sd0 || pb[i] !== 4'sd0) begin failures++; $display("FAIL idle_zero id=%0d got=%0d/%0d exp=0/0", i, pg[i], pb[i]); end
        end
    endtask

    task automatic test_route_start;
        logic signed [N-1:0] xg;
        do_sweep(10'b0000000100, '0, -1, '0, '0, '0);
        for (int i = 0; i < NUM; i++) begin
            xg = (i == 5) ? 4'sd3 : 4'sd0;
            checks++; if (pg[i] !== xg || pb[i] !== 4'sd0) begin failures++; $display("FAIL start_route id=%0d got=%0d/%0d exp=%0d/0", i, pg[i], pb[i], xg); end
        end
        do_sweep('0, '0, -1, '0, '0, '0);
        for (int i = 0; i < NUM; i++) begin
            checks++; if (pg[i] !== 4'sd0 || pb[i] !== 4'sd0) begin failures++; $display("FAIL start_cleared id=%0d got=%0d/%0d exp=0/0", i, pg[i], pb[i]); end
        end
    endtask

    task automatic test_route_stop;
        logic signed [N-1:0] xg;
        do_sweep('0, 10'b0000000100, -1, '0, '0, '0);
        for (int i = 0; i < NUM; i++) begin
            xg = (i == 5) ? -4'sd3 : 4'sd0;
            checks++; if (pg[i] !== xg || pb[i] !== 4'sd0) begin failures++; $display("FAIL stop_route id=%0d got=%0d/%0d exp=%0d/0", i, pg[i], pb[i], xg); end
        end
    endtask

    task automatic test_start_stop_both;
        do_sweep(10'b0000000100, 10'b0000000100, -1, '0, '0, '0);
        for (int i = 0; i < NUM; i++) begin
            checks++; if (pg[i] !== 4'sd0 || pb[i] !== 4'sd0) begin failures++; $display("FAIL both_nochange id=%0d got=%0d/%0d exp=0/0", i, pg[i], pb[i]); end
        end
    endtask

    task automatic test_late_target;
        logic signed [N-1:0] xg, xb;
        do_sweep(10'b0010000000, '0, -1, '0, '0, '0);
        checks++; if (pg[5] !== 4'sd0 || pb[5] !== 4'sd0) begin failures++; $display("FAIL late_same_sweep got=%0d/%0d exp=0/0", pg[5], pb[5]); end
        do_sweep('0, '0, -1, '0, '0, '0);
        for (int i = 0; i < NUM; i++) begin
            xg = (i == 5) ? 4'sd2 : 4'sd0;
            xb = (i == 5) ? 4'sd1 : 4'sd0;
            checks++; if (pg[i] !== xg || pb[i] !== xb) begin failures++; $display("FAIL late_next_sweep id=%0d got=%0d/%0d exp=%0d/%0d", i, pg[i], pb[i], xg, xb); end
        end
    endtask

    task automatic test_saturation;
        logic signed [N-1:0] xg, xb;
        do_sweep(10'b1000001011, 10'b0001000000, 1, 4'd8, 4'sd5, 4'sd0);
        for (int i = 0; i < NUM; i++) begin
            xg = (i == 8) ? 4'sd7 : 4'sd0;
            checks++; if (pg[i] !== xg || pb[i] !== 4'sd0) begin failures++; $display("FAIL sat_pos id=%0d got=%0d/%0d exp=%0d/0", i, pg[i], pb[i], xg); end
        end
        do_sweep('0, '0, -1, '0, '0, '0);
        for (int i = 0; i < NUM; i++) begin
            xb = (i == 1) ? 4'sd7 : 4'sd0;
            checks++; if (pg[i] !== 4'sd0 || pb[i] !== xb) begin failures++; $display("FAIL sat_neg8 id=%0d got=%0d/%0d exp=0/%0d", i, pg[i], pb[i], xb); end
        end
    endtask

    task automatic test_ext_same_cycle;
        do_sweep('0, '0, 0, 4'd0, 4'sd3, -4'sd2);
        checks++; if (pg[0] !== 4'sd0 || pb[0] !== 4'sd0) begin failures++; $display("FAIL ext_excluded got=%0d/%0d exp=0/0", pg[0], pb[0]); end
        do_sweep('0, '0, -1, '0, '0, '0);
        checks++; if (pg[0] !== 4'sd3 || pb[0] !== -4'sd2) begin failures++; $display("FAIL ext_next_sweep got=%0d/%0d exp=3/-2", pg[0], pb[0]); end
    endtask

    task automatic test_back_to_back;
        logic [IDW-1:0] xi;
        for (int c = 0; c <= 27; c++) begin
            bus.clock_slow = (c == 3 || c == 6);
            xi = (c >= 4 && c <= 13) ? IDW'(c - 4) : (c >= 15 && c <= 24) ? IDW'(c - 15) : SENT;
            checks++; if (bus.neuron_id !== xi) begin failures++; $display("FAIL b2b_id cyc=%0d got=%0d exp=%0d", c, bus.neuron_id, xi); end
            tick;
        end
        bus.clock_slow = 1'b0;
    endtask

    task automatic test_hold;
        logic [IDW-1:0] xi;
        for (int c = 0; c <= 22; c++) begin
            bus.hold       = (c >= 2 && c <= 8);
            bus.clock_slow = (c == 3);
            xi = (c >= 10 && c <= 19) ? IDW'(c - 10) : SENT;
            checks++; if (bus.neuron_id !== xi) begin failures++; $display("FAIL hold_id cyc=%0d got=%0d exp=%0d", c, bus.neuron_id, xi); end
            tick;
        end
        bus.hold       = 1'b0;
        bus.clock_slow = 1'b0;
    endtask

    task automatic test_reset_mid_sweep;
        logic signed [N-1:0] xg;
        do_sweep(10'b0010000000, '0, -1, '0, '0, '0);
        bus.clock_slow = 1'b1;
        tick;
        bus.clock_slow = 1'b0;
        for (int k = 0; k < 4; k++) tick;
        checks++; if (bus.neuron_id !== 4'd4) begin failures++; $display("FAIL pre_reset_id got=%0d exp=4", bus.neuron_id); end
        bus.token_start = 1'b1;
        reset = 1'b1;
        tick;
        bus.token_start = 1'b0;
        checks++; if (bus.neuron_id !== SENT) begin failures++; $display("FAIL midreset_id got=%0d exp=%0d", bus.neuron_id, SENT); end
        checks++; if (bus.new_good_tokens !== 4'sd0 || bus.new_bad_tokens !== 4'sd0) begin failures++; $display("FAIL midreset_out got=%0d/%0d exp=0/0", bus.new_good_tokens, bus.new_bad_tokens); end
        reset = 1'b0;
        tick;
        do_sweep('0, '0, -1, '0, '0, '0);
        for (int i = 0; i < NUM; i++) begin
            checks++; if (pg[i] !== 4'sd0 || pb[i] !== 4'sd0) begin failures++; $display("FAIL pend_cleared id=%0d got=%0d/%0d exp=0/0", i, pg[i], pb[i]); end
        end
        do_sweep(10'b0000000100, '0, -1, '0, '0, '0);
        for (int i = 0; i < NUM; i++) begin
            xg = (i == 5) ? 4'sd3 : 4'sd0;
            checks++; if (pg[i] !== xg || pb[i] !== 4'sd0) begin failures++; $display("FAIL weights_kept id=%0d got=%0d/%0d exp=%0d/0", i, pg[i], pb[i], xg); end
        end
    endtask

    initial begin
        bus.clock_slow  = 1'b0;
        bus.hold        = 1'b0;
        bus.prog_header = 3'b000;
        bus.prog_id     = '0;
        bus.prog_data   = '0;
        bus.ext_valid   = 1'b0;
        bus.ext_id      = '0;
        bus.ext_good    = '0;
        bus.ext_bad     = '0;
        bus.token_start = 1'b0;
        bus.token_stop  = 1'b0;

        test_reset;
        test_idle_sweep;
        test_route_start;
        test_route_stop;
        test_start_stop_both;
        test_late_target;
        test_saturation;
        test_ext_same_cycle;
        test_back_to_back;
        test_hold;
        test_reset_mid_sweep;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tt_um_jleugeri_ttt_token_router.md
# tt_um_jleugeri_ttt_token_router

Sweep sequencer and token router directly upstream of the TTT processor core. Once per slow-clock period it issues the neuron_id sweep 0..NUM_PROCESSORS-1, then the sentinel NUM_PROCESSORS, and presents each neuron's pending good/bad token deltas. It captures the core's token_start/token_stop events 2 cycles later and routes each source's programmed signed weights into the target's pending deltas for the next sweep. An external injection port adds off-chip input tokens.

## Interface
- NUM_PROCESSORS, 10, neurons per core; id width IDW = $clog2(NUM_PROCESSORS+1)
- NEW_TOKENS_BITS, 4, signed width of weights and pending deltas
- PROG_WIDTH, 8, programming data width

- clock_fast  in  1  system clock
- reset  in  1  synchronous, active-high; clock clock_fast
- clock_slow  in  1  sweep trigger; sampled on clock_fast
- hold  in  1  defers sweep starts
- prog_header  in  3  programming opcode, valid only while reset=1
- prog_id  in  IDW  source neuron being programmed
- prog_data  in  PROG_WIDTH  programming value
- ext_valid  in  1  external token injection strobe
- ext_id  in  IDW  injection target
- ext_good, ext_bad  in  NEW_TOKENS_BITS  signed injected deltas
- token_start, token_stop  in  1  event outputs of the core
- neuron_id  out  IDW  id to the core; NUM_PROCESSORS when idle
- new_good_tokens, new_bad_tokens  out  NEW_TOKENS_BITS  signed deltas to the core

## Operation
- Per-source memories: tgt[s] (IDW), gw[s], bw[s] (signed NEW_TOKENS_BITS). Per-target state: pend_g[t], pend_b[t].
- Programming, reset=1 only: 3'b100 sets tgt[prog_id]=prog_data[IDW-1:0]; 3'b101 sets gw = low NEW_TOKENS_BITS bits of prog_data; 3'b110 sets bw the same way. Other headers are ignored, including the core's 001-011. prog_id >= NUM_PROCESSORS is ignored.
- Reset clears pend_*, the FSM, the slow-edge detector, the start request and the id delay line. It does not alter tgt/gw/bw.
- FSM IDLE -> SWEEP -> IDLE. The slow edge is clock_slow=1 while its registered value is 0; the edge sets start_req. In IDLE with start_req=1 and hold=0, go to SWEEP with cnt=0 and clear start_req. In SWEEP, neuron_id=cnt and cnt increments. After the cycle with cnt=NUM_PROCESSORS-1, return to IDLE.
- In IDLE, neuron_id=NUM_PROCESSORS and the new_* outputs are 0.
- In the SWEEP cycle for id i, new_good/bad = pend_g/b[i], and pend_*[i] is overwritten with only the deltas arriving that cycle. The read-and-clear is atomic, so no event is lost or double-counted.
- Event capture: the id delay line d1<=neuron_id, d2<=d1. token_start/stop are accepted only when d2 < NUM_PROCESSORS. Events are ignored while d2 is the sentinel, because the core's event outputs are stale then.
  - start from source s=d2: pend[tgt[s]] += (gw[s], bw[s])
  - stop from source s=d2: pend[tgt[s]] -= (gw[s], bw[s])
  - both asserted: no change
  - tgt[s] >= NUM_PROCESSORS: event dropped
- Injection: when ext_valid=1 and ext_id < NUM_PROCESSORS, pend[ext_id] += ext deltas.
- Arithmetic: the router term and the injection term are summed in NEW_TOKENS_BITS+2 bits and saturated once to [-2^(N-1), 2^(N-1)-1] (-8..7 for N=4). Negation of -8 saturates to +7.

## Timing
- Slow edge at cycle t, FSM idle: neuron_id=0 at t+1 ... NUM_PROCESSORS-1 at t+NUM_PROCESSORS, sentinel from t+NUM_PROCESSORS+1.
- Edges that arrive during SWEEP or under hold set start_req; multiple edges collapse into one start. The next sweep begins in the first IDLE cycle with hold=0, so at least one sentinel cycle always separates sweeps.
- Event latency: the event for id i issued at cycle c is sampled at c+2 and visible in pend at c+3.
- Events landing on a target already read in this sweep apply in the next sweep.
- Reset during SWEEP: neuron_id=NUM_PROCESSORS on the next cycle; in-flight events are discarded.
- Output reset values: neuron_id=NUM_PROCESSORS, new_good_tokens=0, new_bad_tokens=0.

## Structure
- Shared package ttt_pkg holds: the prog_header opcodes (core 001/010/011, router 100/101/110) and the state enum {IDLE, SWEEP}.
- The pending-update arithmetic goes in one sub-module, tt_um_jleugeri_ttt_sat_accum. It combines current value, ±weight and injection into one saturated result and is instantiated for both good and bad.

## Test plan
- Program tgt[2]=5, gw[2]=3, bw[2]=0. One sweep, then force token_start at the d2=2 slot -> next sweep presents new_good_tokens=3 for id 5, and 0 for all other ids.
- Same setup with token_stop -> next sweep id 5 presents -3. Start and stop in the same cycle -> 0.
- gw=7 with three starts onto one target plus ext_good=+5 -> 7 (saturates). bw=-8 stop -> +7.
- clock_slow edges at cycles 3 and 6 (mid-sweep) -> exactly two sweeps, separated by one sentinel cycle. hold=1 across an edge -> start deferred until hold falls.
- ext_valid for id 0 in the same cycle neuron_id=0 is read -> presented value excludes the injection; the next sweep presents it.
- Reset asserted mid-sweep at id 4 -> neuron_id=NUM_PROCESSORS the next cycle, all pend cleared, weights retained, and a later sweep routes correctly.
